// File: rtl/wfg_wb_arb_pkg.sv
// Shared types for the wfg Wishbone round-robin arbiter.
package wfg_wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_ERR
  } arb_state_t;

  localparam int MAX_MASTERS = 8;

endpackage

// File: rtl/wfg_wb_arbiter_if.sv
// Bus bundle between NUM_MASTERS Wishbone masters, the arbiter and the single slave.
interface wfg_wb_arbiter_if #(
  parameter int BUSW        = 32,
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]      m_cyc_i;
  logic [NUM_MASTERS-1:0]      m_stb_i;
  logic [NUM_MASTERS-1:0]      m_we_i;
  logic [NUM_MASTERS*4-1:0]    m_sel_i;
  logic [NUM_MASTERS*BUSW-1:0] m_adr_i;
  logic [NUM_MASTERS*BUSW-1:0] m_dat_i;
  logic [BUSW-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]      m_ack_o;
  logic [NUM_MASTERS-1:0]      m_err_o;
  logic [NUM_MASTERS-1:0]      m_gnt_o;
  logic                        s_cyc_o;
  logic                        s_stb_o;
  logic                        s_we_o;
  logic [3:0]                  s_sel_o;
  logic [BUSW-1:0]             s_adr_o;
  logic [BUSW-1:0]             s_dat_o;
  logic [BUSW-1:0]             s_dat_i;
  logic                        s_ack_i;

  // slave: the arbiter, which is the slave seen by every master and drives the real slave.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, m_gnt_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  // master: the surroundings (requesting masters plus the shared slave).
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, m_gnt_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wfg_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module wfg_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  logic [N-1:0] rot;
  logic         found;
  int           pos;

  always_comb begin
    // Rotate the doubled vector so master ptr+1 sits at bit 0, then take the lowest set bit.
    rot     = N'({req, req} >> (int'(ptr) + 1));
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        found    = 1'b1;
        pos      = (int'(ptr) + 1 + i) % N;
        gnt[pos] = 1'b1;
        gnt_idx  = IW'(pos);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/wfg_wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter in front of the wfg_core_top register slave,
// with a watchdog that aborts transfers the slave never acknowledges.
module wfg_wb_arbiter #(
  parameter int BUSW           = 32,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wfg_wb_arbiter_if.slave  bus
);
  import wfg_wb_arb_pkg::*;

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IW-1:0]          gidx_q;
  logic [IW-1:0]          ptr_q;
  logic [WW-1:0]          wdog_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   any_req;
  logic                   in_grant;
  logic                   g_cyc;
  logic                   g_stb;
  logic                   abort;

  wfg_rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_rr (
    .req     (bus.m_cyc_i),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  assign in_grant = (state == ARB_GRANT);
  assign g_cyc    = bus.m_cyc_i[gidx_q];
  assign g_stb    = bus.m_stb_i[gidx_q];

  // A timeout fires only on a live, still-unacked stb; an ack in the same cycle wins.
  assign abort = in_grant && g_cyc && g_stb && !bus.s_ack_i && (wdog_q == WD_LIMIT);

  assign bus.s_cyc_o = in_grant && g_cyc && !abort;
  assign bus.s_stb_o = in_grant && g_stb && !abort;
  assign bus.s_we_o  = in_grant && bus.m_we_i[gidx_q];
  assign bus.s_sel_o = in_grant ? bus.m_sel_i[4*int'(gidx_q) +: 4] : '0;
  assign bus.s_adr_o = in_grant ? bus.m_adr_i[BUSW*int'(gidx_q) +: BUSW] : '0;
  assign bus.s_dat_o = in_grant ? bus.m_dat_i[BUSW*int'(gidx_q) +: BUSW] : '0;

  assign bus.m_dat_o = in_grant ? bus.s_dat_i : '0;
  assign bus.m_ack_o = (in_grant && bus.s_ack_i && !wb_rst_i) ? gnt_q : '0;
  assign bus.m_err_o = (abort && !wb_rst_i) ? gnt_q : '0;
  assign bus.m_gnt_o = gnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= ARB_IDLE;
      gnt_q  <= '0;
      gidx_q <= '0;
      ptr_q  <= IW'(NUM_MASTERS - 1);
      wdog_q <= '0;
    end else begin
      if (in_grant && bus.s_stb_o && !bus.s_ack_i) begin
        if (wdog_q != WD_LIMIT) wdog_q <= wdog_q + WW'(1);
      end else begin
        wdog_q <= '0;
      end

      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            gnt_q  <= pick_gnt;
            gidx_q <= pick_idx;
            state  <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!g_cyc) begin
            gnt_q <= '0;
            ptr_q <= gidx_q;
            state <= ARB_IDLE;
          end else if (abort) begin
            state <= ARB_ERR;
          end
        end
        ARB_ERR: begin
          // The aborted master keeps the bus (disconnected) until it ends its tenure.
          if (!g_cyc) begin
            gnt_q <= '0;
            ptr_q <= gidx_q;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
